cpu_trace_line_arbiter: RTL and testbench

//  Shares one cpu_checker trace-format checker among NUM_SRC character sources. Grants one source
//  per trace line (round-robin), buffers the whole line ending in '#', clears the checker, replays
//  the line to it on contiguous cycles, and reports the checker verdict tagged with the source id.

---
 rtl/cpu_trace_line_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_cpu_trace_line_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_line_arbiter.sv
// Round-robin arbiter that lets several trace sources share one cpu_checker.
// A granted source's whole line is buffered, then replayed to a freshly cleared checker.
module cpu_trace_line_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int MAX_LEN = 63,
    parameter int LEN_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_char,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 chk_reset,
    output logic [7:0]           chk_char,
    input  logic [1:0]           chk_format,
    output logic                 res_valid,
    output logic [SRC_W-1:0]     res_src,
    output logic [1:0]           res_type,
    output logic                 res_abort
);

    localparam logic [7:0] EOL_CHAR = 8'h23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CLEAR,
        S_REPLAY,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] grant_inc;
    logic [SRC_W-1:0] pick;
    logic             pick_found;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] rd_ptr;
    logic [7:0]       grant_char;
    logic             grant_valid;
    logic             accept;
    logic             last_slot;
    logic             is_eol;

    logic [7:0] line_buf [MAX_LEN];

    // First requester at or after rr_ptr, wrapping at NUM_SRC rather than 2**SRC_W.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] idx_s;
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        idx_s      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_s = SRC_W'(idx);
            if (!pick_found && src_valid[idx_s]) begin
                pick_found = 1'b1;
                pick       = idx_s;
            end
        end
    end

    always_comb begin
        grant_char  = 8'h00;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == SRC_W'(i)) begin
                grant_char  = src_char[8*i +: 8];
                grant_valid = src_valid[i];
            end
        end
    end

    assign accept    = (state == S_COLLECT) && grant_valid;
    assign last_slot = (len == LEN_W'(MAX_LEN - 1));
    assign is_eol    = (grant_char == EOL_CHAR);
    assign grant_inc = (int'(grant) == NUM_SRC - 1) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        src_ready  = '0;
        chk_reset  = 1'b1;
        chk_char   = 8'h00;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    src_ready[i] = (grant == SRC_W'(i));
                end
                if (accept) begin
                    if (is_eol) begin
                        state_next = S_CLEAR;
                    end else if (last_slot) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_CLEAR: begin
                state_next = S_REPLAY;
            end
            S_REPLAY: begin
                chk_reset = 1'b0;
                chk_char  = line_buf[rd_ptr];
                if (rd_ptr == len - 1'b1) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                chk_reset  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The checker verdict is only meaningful in WAIT, right after '#' has been replayed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= '0;
            grant     <= '0;
            len       <= '0;
            rd_ptr    <= '0;
            res_valid <= 1'b0;
            res_src   <= '0;
            res_type  <= 2'b00;
            res_abort <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant <= pick;
                        len   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        len <= len + 1'b1;
                        if (!is_eol && last_slot) begin
                            res_valid <= 1'b1;
                            res_abort <= 1'b1;
                            res_type  <= 2'b00;
                            res_src   <= grant;
                            rr_ptr    <= grant_inc;
                        end
                    end
                end
                S_CLEAR: begin
                    rd_ptr <= '0;
                end
                S_REPLAY: begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                S_WAIT: begin
                    res_valid <= 1'b1;
                    res_abort <= 1'b0;
                    res_type  <= chk_format;
                    res_src   <= grant;
                    rr_ptr    <= grant_inc;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            line_buf[len] <= grant_char;
        end
    end

endmodule

// File: tb/tb_cpu_trace_line_arbiter.sv
// Bench for cpu_trace_line_arbiter: vector table of single-source lines plus
// hand-written sequences for concurrent sources and a reset during replay.
module tb_cpu_trace_line_arbiter;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;
    localparam int MAX_LEN = 63;
    localparam int LEN_W   = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_char;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 chk_reset;
    logic [7:0]           chk_char;
    logic [1:0]           chk_format;
    logic                 res_valid;
    logic [SRC_W-1:0]     res_src;
    logic [1:0]           res_type;
    logic                 res_abort;

    logic       v  [NUM_SRC];
    logic [7:0] ch [NUM_SRC];

    always #5 clk = ~clk;

    always_comb begin
        src_valid = '0;
        src_char  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_valid[i]       = v[i];
            src_char[8*i +: 8] = ch[i];
        end
    end

    cpu_trace_line_arbiter #(
        .NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_char(src_char),
        .src_ready(src_ready), .chk_reset(chk_reset), .chk_char(chk_char),
        .chk_format(chk_format), .res_valid(res_valid), .res_src(res_src),
        .res_type(res_type), .res_abort(res_abort)
    );

    // Checker model: verdict depends on the first replayed char of the line.
    logic [7:0] first_char = 8'h61;
    logic [1:0] model_fmt;
    always_comb begin
        model_fmt = 2'b01;
        if (first_char < 8'h41) model_fmt = 2'b00;
        else if (first_char < 8'h61) model_fmt = 2'b10;
    end
    assign chk_format = (!chk_reset && chk_char == 8'h00) ? model_fmt : 2'b00;

    typedef struct packed {
        logic [1:0]  src;
        logic [1:0]  typ;
        logic        abort;
        logic [31:0] cyc;
    } res_t;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] len;
        logic [7:0] first;
        logic       term;
        logic [7:0] stall_at;
        logic [7:0] stall_len;
        logic [1:0] exp_type;
        logic       exp_abort;
    } vec_t;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         low_cnt = 0;
    int         cut_lines = 0;
    int         ready_viol = 0;
    logic [7:0] cur_line [$];
    int         line_len_q [$];
    bit         line_ok_q [$];
    res_t       res_q [$];
    vec_t       vecs [7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        res_t r;
        int   n;
        bit   ok;
        if ($countones(src_ready) > 1) ready_viol++;
        if (res_valid) begin
            r.src   = res_src;
            r.typ   = res_type;
            r.abort = res_abort;
            r.cyc   = cyc;
            res_q.push_back(r);
        end
        if (chk_reset) begin
            if (cur_line.size() != 0) cut_lines++;
            cur_line.delete();
        end else begin
            low_cnt++;
            if (chk_char != 8'h00) begin
                if (cur_line.size() == 0) first_char = chk_char;
                cur_line.push_back(chk_char);
            end else begin
                n  = cur_line.size();
                ok = (n > 0) && (cur_line[n-1] == 8'h23);
                for (int i = 0; i < n - 1; i++) begin
                    if (cur_line[i] != first_char + 8'(i % 20)) ok = 0;
                end
                line_len_q.push_back(n);
                line_ok_q.push_back(ok);
                cur_line.delete();
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen_char(input logic [7:0] first, input int i,
                                            input int len, input bit term);
        if (term && i == len - 1) return 8'h23;
        return first + 8'(i % 20);
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic clear_logs();
        res_q.delete();
        line_len_q.delete();
        line_ok_q.delete();
        low_cnt   = 0;
        cut_lines = 0;
    endtask

    // Sends one line, returning the cycle count just after the final handshake.
    task automatic apply_stimulus(input int src, input int len, input logic [7:0] first,
                                  input bit term, input int stall_at, input int stall_len,
                                  output int hs_cyc);
        bit rdy;
        int budget;
        hs_cyc = 0;
        for (int i = 0; i < len; i++) begin
            if (stall_len > 0 && i == stall_at) begin
                v[src] = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            ch[src] = gen_char(first, i, len, term);
            v[src]  = 1'b1;
            budget  = 0;
            rdy     = 0;
            while (!rdy && budget < 500) begin
                @(negedge clk);
                rdy = src_ready[src];
                @(posedge clk);
                #1;
                budget++;
            end
            if (!rdy) begin
                check($sformatf("handshake_src%0d", src), int'(rdy), 1);
                v[src] = 1'b0;
                return;
            end
            hs_cyc = cyc;
        end
        v[src] = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        for (int k = 0; k < budget && res_q.size() < n; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input int t, input int hs_cyc);
        int len;
        len = int'(vecs[t].len);
        check($sformatf("v%0d_res_count", t), res_q.size(), 1);
        if (res_q.size() >= 1) begin
            check($sformatf("v%0d_res_src", t), int'(res_q[0].src), int'(vecs[t].src));
            check($sformatf("v%0d_res_type", t), int'(res_q[0].typ), int'(vecs[t].exp_type));
            check($sformatf("v%0d_res_abort", t), int'(res_q[0].abort), int'(vecs[t].exp_abort));
            check($sformatf("v%0d_latency", t), int'(res_q[0].cyc) - hs_cyc,
                  vecs[t].exp_abort ? 0 : len + 2);
        end
        check($sformatf("v%0d_line_count", t), line_len_q.size(), vecs[t].exp_abort ? 0 : 1);
        check($sformatf("v%0d_low_cycles", t), low_cnt, vecs[t].exp_abort ? 0 : len + 1);
        if (!vecs[t].exp_abort && line_len_q.size() >= 1) begin
            check($sformatf("v%0d_line_len", t), line_len_q[0], len);
            check($sformatf("v%0d_line_ok", t), int'(line_ok_q[0]), 1);
        end
    endtask

    initial begin
        int hs;
        int ha;
        int hb;
        int exp_src [4];
        int exp_typ [4];

        vecs[0] = '{src:2'd0, len:8'd3,  first:8'h61, term:1'b1, stall_at:8'd0, stall_len:8'd0,  exp_type:2'b01, exp_abort:1'b0};
        vecs[1] = '{src:2'd1, len:8'd5,  first:8'h41, term:1'b1, stall_at:8'd0, stall_len:8'd0,  exp_type:2'b10, exp_abort:1'b0};
        vecs[2] = '{src:2'd3, len:8'd63, first:8'h61, term:1'b0, stall_at:8'd0, stall_len:8'd0,  exp_type:2'b00, exp_abort:1'b1};
        vecs[3] = '{src:2'd2, len:8'd63, first:8'h61, term:1'b1, stall_at:8'd0, stall_len:8'd0,  exp_type:2'b01, exp_abort:1'b0};
        vecs[4] = '{src:2'd1, len:8'd1,  first:8'h23, term:1'b1, stall_at:8'd0, stall_len:8'd0,  exp_type:2'b00, exp_abort:1'b0};
        vecs[5] = '{src:2'd1, len:8'd8,  first:8'h61, term:1'b1, stall_at:8'd4, stall_len:8'd10, exp_type:2'b01, exp_abort:1'b0};
        vecs[6] = '{src:2'd3, len:8'd6,  first:8'h41, term:1'b1, stall_at:8'd0, stall_len:8'd0,  exp_type:2'b10, exp_abort:1'b0};

        for (int i = 0; i < NUM_SRC; i++) begin
            v[i]  = 1'b0;
            ch[i] = 8'h00;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_src_ready", int'(src_ready), 0);
        check("rst_chk_reset", int'(chk_reset), 1);
        check("rst_chk_char", int'(chk_char), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_src", int'(res_src), 0);
        check("rst_res_type", int'(res_type), 0);
        check("rst_res_abort", int'(res_abort), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int t = 0; t < 7; t++) begin
            clear_logs();
            apply_stimulus(int'(vecs[t].src), int'(vecs[t].len), vecs[t].first, vecs[t].term,
                           int'(vecs[t].stall_at), int'(vecs[t].stall_len), hs);
            wait_results(1, 200);
            check_output(t, hs);
        end

        // Two sources requesting continuously from reset alternate line by line.
        do_reset(2);
        clear_logs();
        fork
            begin
                apply_stimulus(0, 4, 8'h61, 1'b1, 0, 0, ha);
                apply_stimulus(0, 4, 8'h61, 1'b1, 0, 0, ha);
            end
            begin
                apply_stimulus(2, 4, 8'h41, 1'b1, 0, 0, hb);
                apply_stimulus(2, 4, 8'h41, 1'b1, 0, 0, hb);
            end
        join
        wait_results(4, 200);
        exp_src = '{0, 2, 0, 2};
        exp_typ = '{1, 2, 1, 2};
        check("rr_res_count", res_q.size(), 4);
        check("rr_line_count", line_len_q.size(), 4);
        check("rr_cut_lines", cut_lines, 0);
        for (int k = 0; k < 4; k++) begin
            if (res_q.size() > k) begin
                check($sformatf("rr%0d_src", k), int'(res_q[k].src), exp_src[k]);
                check($sformatf("rr%0d_type", k), int'(res_q[k].typ), exp_typ[k]);
                check($sformatf("rr%0d_abort", k), int'(res_q[k].abort), 0);
            end
            if (line_len_q.size() > k) begin
                check($sformatf("rr%0d_line_len", k), line_len_q[k], 4);
                check($sformatf("rr%0d_line_ok", k), int'(line_ok_q[k]), 1);
            end
        end

        // Reset pulse in the middle of a replay.
        do_reset(2);
        clear_logs();
        apply_stimulus(2, 3, 8'h61, 1'b1, 0, 0, hs);
        wait_results(1, 200);
        check("pre_rst_count", res_q.size(), 1);
        if (res_q.size() >= 1) check("pre_rst_src", int'(res_q[0].src), 2);
        clear_logs();
        apply_stimulus(1, 10, 8'h61, 1'b1, 0, 0, hs);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_src_ready", int'(src_ready), 0);
        check("mid_chk_reset", int'(chk_reset), 1);
        check("mid_chk_char", int'(chk_char), 0);
        check("mid_res_valid", int'(res_valid), 0);
        check("mid_res_src", int'(res_src), 0);
        check("mid_res_type", int'(res_type), 0);
        check("mid_res_abort", int'(res_abort), 0);
        repeat (20) @(posedge clk);
        #1;
        check("mid_no_result", res_q.size(), 0);
        check("mid_cut_lines", cut_lines, 1);
        check("mid_no_wait", line_len_q.size(), 0);
        clear_logs();
        fork
            apply_stimulus(1, 3, 8'h61, 1'b1, 0, 0, ha);
            apply_stimulus(3, 3, 8'h41, 1'b1, 0, 0, hb);
        join
        wait_results(2, 200);
        check("post_rst_count", res_q.size(), 2);
        if (res_q.size() >= 2) begin
            check("post_rst_first_src", int'(res_q[0].src), 1);
            check("post_rst_second_src", int'(res_q[1].src), 3);
            check("post_rst_second_type", int'(res_q[1].typ), 2);
        end

        check("ready_onehot", ready_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
